// File: rtl/time_set_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_set_pkg
// Description : Shared types, state codes, per-field BCD bounds and the
//               bounded two-digit BCD increment used by the time editor.
// Revision    : 1.0 - initial release
// ============================================================================
package time_set_pkg;

    // Editor states, kept as explicit-width constants for legacy compatibility
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_EDIT   = 2'd1;
    localparam state_t ST_COMMIT = 2'd2;

    // Selectable field; the encoding is also the FIELD output value
    typedef enum logic [1:0] {
        F_SEC  = 2'd0,
        F_MIN  = 2'd1,
        F_HOUR = 2'd2,
        F_DAY  = 2'd3
    } field_e;

    // Per-field bounds as BCD tens/units digits
    localparam logic [3:0] SEC_MIN_T  = 4'd0;
    localparam logic [3:0] SEC_MIN_U  = 4'd0;
    localparam logic [3:0] SEC_MAX_T  = 4'd5;
    localparam logic [3:0] SEC_MAX_U  = 4'd9;
    localparam logic [3:0] MIN_MIN_T  = 4'd0;
    localparam logic [3:0] MIN_MIN_U  = 4'd0;
    localparam logic [3:0] MIN_MAX_T  = 4'd5;
    localparam logic [3:0] MIN_MAX_U  = 4'd9;
    localparam logic [3:0] HOUR_MIN_T = 4'd0;
    localparam logic [3:0] HOUR_MIN_U = 4'd0;
    localparam logic [3:0] HOUR_MAX_T = 4'd2;
    localparam logic [3:0] HOUR_MAX_U = 4'd3;
    localparam logic [3:0] DAY_MIN_T  = 4'd0;
    localparam logic [3:0] DAY_MIN_U  = 4'd1;
    localparam logic [3:0] DAY_MAX_T  = 4'd3;
    localparam logic [3:0] DAY_MAX_U  = 4'd1;

    // Increment a two-digit BCD field, returning {tens, units}. Any value at
    // or above the field maximum (including bad snapshots) reloads the minimum.
    // The carry stays inside the field.
    function automatic logic [7:0] bcd_inc(input field_e fld,
                                           input logic [3:0] tens,
                                           input logic [3:0] units);
        logic [7:0] max_v;
        logic [7:0] min_v;
        logic [7:0] res;
        case (fld)
            F_SEC: begin
                max_v = {SEC_MAX_T, SEC_MAX_U};
                min_v = {SEC_MIN_T, SEC_MIN_U};
            end
            F_MIN: begin
                max_v = {MIN_MAX_T, MIN_MAX_U};
                min_v = {MIN_MIN_T, MIN_MIN_U};
            end
            F_HOUR: begin
                max_v = {HOUR_MAX_T, HOUR_MAX_U};
                min_v = {HOUR_MIN_T, HOUR_MIN_U};
            end
            default: begin
                max_v = {DAY_MAX_T, DAY_MAX_U};
                min_v = {DAY_MIN_T, DAY_MIN_U};
            end
        endcase
        if ({tens, units} >= max_v) begin
            res = min_v;
        end else if (units >= 4'd9) begin
            res = {tens + 4'd1, 4'd0};
        end else begin
            res = {tens, units + 4'd1};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl_if
// Description : Preset bus between the time editor and the time-keeping
//               counter: live digits in, SET strobe plus preset digits out.
// Revision    : 1.0 - initial release
// ============================================================================
interface time_set_ctrl_if;

    // Live time from the counter
    logic [3:0] CSEC0, CSEC1, CMIN0, CMIN1, CHOUR0, CHOUR1, CDAY0, CDAY1;

    // Preset bus toward the counter
    logic       SET;
    logic [3:0] SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1;

    // Editor side
    modport master (
        input  CSEC0, CSEC1, CMIN0, CMIN1, CHOUR0, CHOUR1, CDAY0, CDAY1,
        output SET,
        output SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1
    );

    // Counter side
    modport slave (
        output CSEC0, CSEC1, CMIN0, CMIN1, CHOUR0, CHOUR1, CDAY0, CDAY1,
        input  SET,
        input  SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1
    );

endinterface
`default_nettype wire

// File: rtl/key_edge.sv
`default_nettype none
// ============================================================================
// Module      : key_edge
// Description : Multi-stage synchronizer for a raw push-button level followed
//               by a rising-edge detector; a held key yields one pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module key_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic CLK,
    input  wire logic RSTN,
    input  wire logic key,
    output logic      rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw level through the synchronizer and remember the last output
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Time-set editor. MODE snapshots the live time and enters
//               edit, NEXT selects a field, UP increments it within its BCD
//               range, a second MODE commits with a one-cycle SET strobe.
//               Optional display blink enabled by macro TIME_SET_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BLINK_DIV   = 2500
) (
    input  wire logic        CLK,
    input  wire logic        RSTN,
    input  wire logic        KEY_MODE,
    input  wire logic        KEY_NEXT,
    input  wire logic        KEY_UP,
    time_set_ctrl_if.master  bus,
    output logic             EDIT,
    output logic [1:0]       FIELD,
    output logic             BLINK
);

    logic       mode_ev, next_ev, up_ev;
    state_t     state_q;
    field_e     field_q;
    logic       set_q;
    logic       edit_q;
    logic [3:0] s_tens  [4];
    logic [3:0] s_units [4];
    logic [7:0] inc_val;

    key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_mode (
        .CLK (CLK), .RSTN (RSTN), .key (KEY_MODE), .rise (mode_ev)
    );
    key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_next (
        .CLK (CLK), .RSTN (RSTN), .key (KEY_NEXT), .rise (next_ev)
    );
    key_edge #(.SYNC_STAGES(SYNC_STAGES)) u_key_up (
        .CLK (CLK), .RSTN (RSTN), .key (KEY_UP), .rise (up_ev)
    );

    assign inc_val = bcd_inc(field_q, s_tens[field_q], s_units[field_q]);

    // Editor FSM: snapshot, field edits, and the single-cycle commit strobe
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            field_q <= F_SEC;
            set_q   <= 1'b0;
            edit_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s_tens[i]  <= 4'd0;
                s_units[i] <= (i == 3) ? 4'd1 : 4'd0;
            end
        end else begin
            set_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (mode_ev) begin
                        s_units[F_SEC]  <= bus.CSEC0;
                        s_tens[F_SEC]   <= bus.CSEC1;
                        s_units[F_MIN]  <= bus.CMIN0;
                        s_tens[F_MIN]   <= bus.CMIN1;
                        s_units[F_HOUR] <= bus.CHOUR0;
                        s_tens[F_HOUR]  <= bus.CHOUR1;
                        s_units[F_DAY]  <= bus.CDAY0;
                        s_tens[F_DAY]   <= bus.CDAY1;
                        field_q         <= F_SEC;
                        edit_q          <= 1'b1;
                        state_q         <= ST_EDIT;
                    end
                end
                ST_EDIT: begin
                    // MODE takes priority and discards same-cycle NEXT/UP
                    if (mode_ev) begin
                        set_q   <= 1'b1;
                        edit_q  <= 1'b0;
                        state_q <= ST_COMMIT;
                    end else begin
                        // UP lands on the current field before NEXT moves it
                        if (up_ev) begin
                            s_tens[field_q]  <= inc_val[7:4];
                            s_units[field_q] <= inc_val[3:0];
                        end
                        if (next_ev) begin
                            field_q <= field_e'(field_q + 2'd1);
                        end
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.SET    = set_q;
    assign bus.SSEC0  = s_units[F_SEC];
    assign bus.SSEC1  = s_tens[F_SEC];
    assign bus.SMIN0  = s_units[F_MIN];
    assign bus.SMIN1  = s_tens[F_MIN];
    assign bus.SHOUR0 = s_units[F_HOUR];
    assign bus.SHOUR1 = s_tens[F_HOUR];
    assign bus.SDAY0  = s_units[F_DAY];
    assign bus.SDAY1  = s_tens[F_DAY];
    assign EDIT       = edit_q;
    assign FIELD      = field_q;

`ifdef TIME_SET_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_q;

    // Blink divider; restarts solid after every edit and outside edit mode
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (!edit_q || next_ev || up_ev) begin
            blink_cnt <= '0;
            blink_q   <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_q   <= ~blink_q;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign BLINK = blink_q;
`else
    logic unused_blink_div;
    assign unused_blink_div = ^BLINK_DIV;
    assign BLINK            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_set_ctrl
// Description : Directed self-checking bench for the time-set editor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_set_ctrl;

    logic       CLK      = 1'b0;
    logic       RSTN     = 1'b0;
    logic       KEY_MODE = 1'b0;
    logic       KEY_NEXT = 1'b0;
    logic       KEY_UP   = 1'b0;
    logic       EDIT;
    logic [1:0] FIELD;
    logic       BLINK;

    int total = 0;
    int bad   = 0;

    time_set_ctrl_if bus ();

    time_set_ctrl #(
        .SYNC_STAGES (2),
        .BLINK_DIV   (4)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .KEY_MODE (KEY_MODE),
        .KEY_NEXT (KEY_NEXT),
        .KEY_UP   (KEY_UP),
        .bus      (bus),
        .EDIT     (EDIT),
        .FIELD    (FIELD),
        .BLINK    (BLINK)
    );

    always #5 CLK = ~CLK;

    // Preset digits packed as {D1,D0,H1,H0,M1,M0,S1,S0}
    function automatic logic [31:0] get_s();
        return {bus.SDAY1, bus.SDAY0, bus.SHOUR1, bus.SHOUR0,
                bus.SMIN1, bus.SMIN0, bus.SSEC1, bus.SSEC0};
    endfunction

    task automatic set_cur(input logic [31:0] v);
        {bus.CDAY1, bus.CDAY0, bus.CHOUR1, bus.CHOUR0,
         bus.CMIN1, bus.CMIN0, bus.CSEC1, bus.CSEC0} = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Press keys together, wait until the event has been applied, release, settle
    task automatic tap(input bit m, input bit n, input bit u);
        @(negedge CLK);
        KEY_MODE = m;
        KEY_NEXT = n;
        KEY_UP   = u;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        KEY_MODE = 1'b0;
        KEY_NEXT = 1'b0;
        KEY_UP   = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    // Commit via MODE (optionally with UP rising on the same cycle), observing SET
    task automatic do_commit(input bit with_up, output int n_set,
                             output logic [31:0] s_at, output logic e_at);
        @(negedge CLK);
        KEY_MODE = 1'b1;
        KEY_UP   = with_up;
        n_set    = 0;
        s_at     = '0;
        e_at     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.SET === 1'b1) begin
                n_set++;
                s_at = get_s();
                e_at = EDIT;
            end
        end
        KEY_MODE = 1'b0;
        KEY_UP   = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    initial begin
        int          n_set;
        logic [31:0] s_at;
        logic        e_at;
        int          cnt;
        logic        prev_b;

        // Reset state
        set_cur(32'h07123456);
        repeat (3) @(negedge CLK);
        check("rst_set",   {31'd0, bus.SET}, 32'd0);
        check("rst_edit",  {31'd0, EDIT},    32'd0);
        check("rst_field", {30'd0, FIELD},   32'd0);
        check("rst_blink", {31'd0, BLINK},   32'd0);
        check("rst_s",     get_s(),          32'h01000000);
        RSTN = 1'b1;
        repeat (2) @(negedge CLK);

        // Enter edit: snapshot day07 12:34:56
        tap(1, 0, 0);
        check("enter_edit",  {31'd0, EDIT},    32'd1);
        check("enter_field", {30'd0, FIELD},   32'd0);
        check("enter_set",   {31'd0, bus.SET}, 32'd0);
        check("enter_s",     get_s(),          32'h07123456);

        // SEC 56 -> 59, then wrap to 00 with MIN untouched
        repeat (3) tap(0, 0, 1);
        check("sec_59", get_s(), 32'h07123459);
        tap(0, 0, 1);
        check("sec_wrap", get_s(), 32'h07123400);

        // Move to HOUR, run 12 -> 23, wrap to 00 with DAY untouched
        tap(0, 1, 0);
        tap(0, 1, 0);
        check("field_hour", {30'd0, FIELD}, 32'd2);
        repeat (11) tap(0, 0, 1);
        check("hour_23", get_s(), 32'h07233400);
        tap(0, 0, 1);
        check("hour_wrap", get_s(), 32'h07003400);

        // Commit: exactly one SET with digits stable, EDIT low during it
        do_commit(0, n_set, s_at, e_at);
        check("commit1_nset", n_set,         32'd1);
        check("commit1_s",    s_at,          32'h07003400);
        check("commit1_edit", {31'd0, e_at}, 32'd0);
        check("commit1_idle", {31'd0, EDIT}, 32'd0);
        check("commit1_hold", get_s(),       32'h07003400);

        // New snapshot day31 10:00:09
        set_cur(32'h31100009);
        tap(1, 0, 0);
        check("snap2_s", get_s(), 32'h31100009);
        tap(0, 0, 1);
        check("sec_09_10", get_s(), 32'h31100010);
        repeat (3) tap(0, 1, 0);
        check("field_day", {30'd0, FIELD}, 32'd3);
        tap(0, 0, 1);
        check("day_31_01", get_s(), 32'h01100010);
        tap(0, 1, 0);
        check("field_wrap", {30'd0, FIELD}, 32'd0);

        // NEXT and UP together: UP on SEC first, then FIELD -> MIN
        tap(0, 1, 1);
        check("nu_s",     get_s(),         32'h01100011);
        check("nu_field", {30'd0, FIELD},  32'd1);

        // Held UP for 1000 cycles gives one increment on MIN
        @(negedge CLK);
        KEY_UP = 1'b1;
        repeat (1000) @(negedge CLK);
        KEY_UP = 1'b0;
        repeat (4) @(negedge CLK);
        check("hold_up", get_s(), 32'h01100111);

        // MODE and UP on the same cycle: commit, no increment
        do_commit(1, n_set, s_at, e_at);
        check("mu_nset", n_set, 32'd1);
        check("mu_s",    s_at,  32'h01100111);

        // UP in IDLE is ignored
        tap(0, 0, 1);
        check("idle_up_s",    get_s(),       32'h01100111);
        check("idle_up_edit", {31'd0, EDIT}, 32'd0);

        // Out-of-range snapshot DAY=35 reloads 01
        set_cur(32'h35000000);
        tap(1, 0, 0);
        repeat (3) tap(0, 1, 0);
        tap(0, 0, 1);
        check("day_35_01", get_s(), 32'h01000000);
        tap(0, 0, 1);
        check("day_01_02", get_s(), 32'h02000000);

        // Reset mid-edit: immediate return to reset values, no SET ever
        n_set = 0;
        @(negedge CLK);
        RSTN = 1'b0;
        #2;
        check("mrst_s",     get_s(),        32'h01000000);
        check("mrst_edit",  {31'd0, EDIT},  32'd0);
        check("mrst_field", {30'd0, FIELD}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (bus.SET === 1'b1) n_set++;
        end
        RSTN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (bus.SET === 1'b1) n_set++;
        end
        check("mrst_noset", n_set, 32'd0);

        // Blink behaviour in edit
        set_cur(32'h07123456);
        tap(1, 0, 0);
`ifdef TIME_SET_BLINK_EN
        cnt    = 0;
        prev_b = BLINK;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (BLINK !== prev_b) cnt++;
            prev_b = BLINK;
        end
        check("blink_toggles", cnt, 32'd4);
        @(negedge CLK);
        KEY_NEXT = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("blink_next_clr", {31'd0, BLINK}, 32'd0);
        check("blink_next_fld", {30'd0, FIELD}, 32'd1);
        KEY_NEXT = 1'b0;
        repeat (3) @(negedge CLK);
        check("blink_solid", {31'd0, BLINK}, 32'd0);
        @(negedge CLK);
        check("blink_first", {31'd0, BLINK}, 32'd1);
`else
        cnt    = 0;
        prev_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (BLINK !== 1'b0) cnt++;
        end
        tap(0, 1, 0);
        if (BLINK !== 1'b0) cnt++;
        prev_b = BLINK;
        check("blink_off",     cnt,              32'd0);
        check("blink_off_end", {31'd0, prev_b},  32'd0);
        check("blink_off_fld", {30'd0, FIELD},   32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-end editor that produces the preset bus (SET plus eight BCD digits) consumed by the clock's time-keeping counter.
- User flow: the MODE key enters edit, which snapshots the running time. NEXT selects a field, UP increments it. A second MODE commits with a one-cycle SET pulse.
- Sits between the board push-buttons and the time counter; the counter's live digits feed back in for the snapshot.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each key input synchronizer (minimum 2).
- BLINK_DIV, 2500, CLK cycles per BLINK half-period (only used with the optional feature).

Ports:
- CLK  in  1  system clock.
- RSTN  in  1  reset, asynchronous, active-low.
- KEY_MODE  in  1  raw level, active-high, asynchronous to CLK; enter or commit edit.
- KEY_NEXT  in  1  raw level, active-high; advance the selected field.
- KEY_UP  in  1  raw level, active-high; increment the selected field.
- CSEC0, CSEC1, CMIN0, CMIN1, CHOUR0, CHOUR1, CDAY0, CDAY1  in  4 each  current BCD time from the counter.
- SET  out  1  one-cycle load strobe.
- SSEC0, SSEC1, SMIN0, SMIN1, SHOUR0, SHOUR1, SDAY0, SDAY1  out  4 each  preset BCD digits, registered.
- EDIT  out  1  high while in the EDIT state.
- FIELD  out  2  selected field: 0=SEC, 1=MIN, 2=HOUR, 3=DAY.
- BLINK  out  1  display blink enable for the selected field.

Behaviour:
- Reset values: SET=0, EDIT=0, FIELD=0, BLINK=0, all S* digits=0 except SDAY0=1. State goes to IDLE.
- Key path: each key passes through a SYNC_STAGES synchronizer, then rising-edge detection. The action occurs SYNC_STAGES+1 cycles after a raw rising edge.
- A held key produces exactly one event.
- IDLE state:
  - MODE event -> copy the C* inputs into the S* registers on that same edge, FIELD<=0, go to EDIT.
  - NEXT and UP events are ignored.
- EDIT state:
  - NEXT event -> FIELD advances SEC->MIN->HOUR->DAY->SEC (wraps 3->0).
  - UP event -> increment the selected two-digit BCD field by 1, with these bounds:
    - SEC and MIN: 00..59, 59->00.
    - HOUR: 00..23, 23->00.
    - DAY: 01..31, 31->01.
  - Units digit 9 -> 0 with a carry into the tens digit. No carry ever propagates into another field.
  - Out-of-range snapshot values: if the value is >= the field max, UP loads the field minimum. Example: snapshot DAY=35, UP -> 01.
  - MODE event -> go to COMMIT. S* digits are frozen from then on.
- COMMIT state: SET=1 for exactly one cycle with the S* digits stable, then IDLE and EDIT=0.
- S* digits hold their last value in IDLE. SET is the only qualifier the consumer uses.
- Simultaneous events in one cycle: MODE wins over NEXT and UP, which are discarded. If NEXT and UP coincide, UP applies to the current field first, then FIELD advances.
- Reset asserted mid-edit: immediately return to IDLE with all reset values. No SET is issued.
- EDIT is a registered output: high from the cycle after the entering MODE event until the cycle SET is asserted (exclusive).

Optional Feature:
- Macro: TIME_SET_BLINK_EN.
- Defined:
  - A counter counts to BLINK_DIV-1 and BLINK toggles at each wrap while EDIT=1.
  - The counter and BLINK are cleared on any NEXT or UP event and whenever not in EDIT.
  - Net effect: the selected field is shown solid right after an edit.
- Undefined: BLINK is tied to 0, and neither the counter nor BLINK_DIV logic exists.

Decomposition:
- Shared package time_set_pkg:
  - State enum {IDLE, EDIT, COMMIT}.
  - Field enum {F_SEC, F_MIN, F_HOUR, F_DAY}.
  - Per-field BCD min/max tens/units constants.
- One sub-module, key_edge: synchronizer plus rising-edge detector, parameterized by SYNC_STAGES, instantiated three times.

Test Plan:
- Reset, then MODE with C*=12:34:56 day 07 -> EDIT=1, S*=day07 12:34:56, FIELD=0, SET=0.
- In EDIT with SEC=59, UP -> SEC=00, MIN unchanged at 34. NEXT ×2 to HOUR=23, UP -> HOUR=00, DAY unchanged.
- DAY=31, UP -> 01. Snapshot DAY=35, UP -> 01. SEC=09, UP -> 10.
- MODE in EDIT -> SET high for exactly 1 cycle with S* stable, then IDLE. KEY_UP held 1000 cycles -> exactly one increment.
- MODE and UP rising on the same cycle in EDIT -> commit with no increment. RSTN pulsed mid-EDIT -> SET never asserted, S* back to 0 and SDAY0=1.
- With TIME_SET_BLINK_EN and BLINK_DIV=4 in EDIT -> BLINK toggles every 4 cycles and clears to 0 on a NEXT event. Without the macro -> BLINK constant 0.
